// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the 16-bit accumulator multicycle
// datapath. It decodes the IR contents and ZeroFlag and drives every datapath
// enable and select. Memory accesses (instruction fetch, load, store) wait for
// MemReady. An optional per-access timeout is set with MEM_TIMEOUT (0 = wait
// forever).
//
// Build option: define CTRL_ILLEGAL_TRAP_EN to route illegal opcodes to a TRAP
// state. TRAP forces PC to 0 and pulses IllegalOp. When the macro is not
// defined, an illegal opcode retires as a NOP from DECODE.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned TMO_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Instruction,
  input  logic        ZeroFlag,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        IorD,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        InstrDone,
  output logic        MemTimeout,
  output logic        IllegalOp
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_LD_WB,
    S_MEM_WR,
    S_JMP,
    S_BRZ,
    S_ALU_R,
    S_R_WB,
    S_ALU_I,
    S_I_WB
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  // PC source selects
  localparam logic [1:0] PCS_INCR   = 2'd0;
  localparam logic [1:0] PCS_JUMP   = 2'd1;
  localparam logic [1:0] PCS_BRANCH = 2'd2;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [1:0] PCS_ZERO   = 2'd3;
`endif

  // ALU B-operand selects
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_ZERO = 2'd2;

  // ALU operations
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOT   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;

  // C-type function codes
  localparam logic [2:0] FN_MOVETO   = 3'b000;
  localparam logic [2:0] FN_MOVEFROM = 3'b001;
  localparam logic [2:0] FN_ADD      = 3'b010;
  localparam logic [2:0] FN_SUB      = 3'b011;
  localparam logic [2:0] FN_AND      = 3'b100;
  localparam logic [2:0] FN_OR       = 3'b101;
  localparam logic [2:0] FN_NOT      = 3'b110;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  state_t           state;
  state_t           state_next;
  logic [TMO_W-1:0] wait_cnt;
  logic             mem_access;
  logic             timeout;

  logic [3:0] opcode;
  logic [2:0] func;
  logic       unused_fields;

  assign opcode        = Instruction[15:12];
  assign func          = Instruction[2:0];
  // Register and address fields feed the datapath directly, not this FSM.
  assign unused_fields = ^Instruction[11:3];

  // Access in progress whose wait cycles are counted.
  assign mem_access = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  // A ready memory takes priority over a timeout in the same cycle.
  assign timeout = (MEM_TIMEOUT != 0) && mem_access && !MemReady && (wait_cnt == TMO_LIMIT);

  // State register and per-access wait counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || timeout) begin
        wait_cnt <= '0;
      end else if (mem_access && !MemReady && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Next-state decode and the combinational control outputs (forced low in reset).
  // NOTE: every signal gets a default before the case so that no path
  // leaves a value unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    PCSource   = PCS_INCR;
    ALUSrcB    = SRCB_REG;
    ALUOp      = ALU_ADD;
    InstrDone  = 1'b0;
    MemTimeout = 1'b0;
    IllegalOp  = 1'b0;

    if (rst) begin
      case (state)
        S_IDLE: state_next = S_FETCH;

        S_FETCH: begin
          if (MemReady) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            PCSource   = PCS_INCR;
            state_next = S_DECODE;
          end else if (timeout) begin
            // Retry the fetch at the same PC with a fresh wait budget.
            MemTimeout = 1'b1;
          end
        end

        S_DECODE: begin
          case (opcode)
            4'b0000: state_next = S_MEM_RD;
            4'b0001: state_next = S_MEM_WR;
            4'b0010: state_next = S_JMP;
            4'b0100: state_next = S_BRZ;
            4'b1000: state_next = S_ALU_R;
            4'b1100, 4'b1101, 4'b1110, 4'b1111: state_next = S_ALU_I;
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              state_next = S_TRAP;
`else
              InstrDone  = 1'b1;
              state_next = S_FETCH;
`endif
            end
          endcase
        end

        S_MEM_RD: begin
          IorD = 1'b1;
          if (MemReady) begin
            state_next = S_LD_WB;
          end else if (timeout) begin
            MemTimeout = 1'b1;
            state_next = S_FETCH;
          end
        end

        S_LD_WB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          InstrDone  = 1'b1;
          state_next = S_FETCH;
        end

        S_MEM_WR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (MemReady) begin
            InstrDone  = 1'b1;
            state_next = S_FETCH;
          end else if (timeout) begin
            // The abandoned store must not write in its final cycle.
            MemWrite   = 1'b0;
            MemTimeout = 1'b1;
            state_next = S_FETCH;
          end
        end

        S_JMP: begin
          PCSource   = PCS_JUMP;
          PCWrite    = 1'b1;
          InstrDone  = 1'b1;
          state_next = S_FETCH;
        end

        S_BRZ: begin
          ALUSrcB    = SRCB_ZERO;
          ALUOp      = ALU_SUB;
          PCSource   = PCS_BRANCH;
          PCWrite    = ZeroFlag;
          InstrDone  = 1'b1;
          state_next = S_FETCH;
        end

        S_ALU_R: begin
          state_next = S_R_WB;
          case (func)
            FN_MOVETO: begin
              ALUSrcB = SRCB_ZERO;
              ALUOp   = ALU_ADD;
            end
            FN_MOVEFROM: ALUOp = ALU_PASSB;
            FN_ADD:      ALUOp = ALU_ADD;
            FN_SUB:      ALUOp = ALU_SUB;
            FN_AND:      ALUOp = ALU_AND;
            FN_OR:       ALUOp = ALU_OR;
            FN_NOT:      ALUOp = ALU_NOT;
            default: begin
              // func 111 is a NOP and retires without a write-back.
              InstrDone  = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end

        S_R_WB: begin
          RegWrite   = 1'b1;
          RegDst     = (func == FN_MOVETO);
          InstrDone  = 1'b1;
          state_next = S_FETCH;
        end

        S_ALU_I: begin
          ALUSrcB    = SRCB_IMM;
          ALUOp      = {1'b0, opcode[1:0]};
          state_next = S_I_WB;
        end

        S_I_WB: begin
          RegWrite   = 1'b1;
          InstrDone  = 1'b1;
          state_next = S_FETCH;
        end

`ifdef CTRL_ILLEGAL_TRAP_EN
        S_TRAP: begin
          PCSource   = PCS_ZERO;
          PCWrite    = 1'b1;
          IllegalOp  = 1'b1;
          state_next = S_FETCH;
        end
`endif

        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule
